// File: rtl/atomic_lock_arbiter.sv
// Arbitrates atomic-lock acquire/release between the OOO core (index 0) and the
// PPL core (index 1), driving lock_table and keeping every 32-bit word single-owner.
//
// state  | meaning
// S_IDLE | no lock held, no acquire pending
// S_WAIT | acquire blocked by the other core; wcnt counts cycles spent blocked
// S_HELD | lock granted; waiting for rel_req
module atomic_lock_arbiter #(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ooo_acq_req,
  input  logic [31:0] ooo_acq_addr,
  output logic        ooo_acq_gnt,
  output logic        ooo_acq_fail,
  input  logic        ooo_rel_req,
  output logic        ooo_rel_ack,
  input  logic        ppl_acq_req,
  input  logic [31:0] ppl_acq_addr,
  output logic        ppl_acq_gnt,
  output logic        ppl_acq_fail,
  input  logic        ppl_rel_req,
  output logic        ppl_rel_ack,
  input  logic [32:0] this_address_locked_by_ooo,
  input  logic [32:0] this_address_locked_by_ppl,
  output logic        ooo_lock,
  output logic [31:0] ooo_locked_address,
  output logic        ooo_unlock,
  output logic        ppl_lock,
  output logic [31:0] ppl_locked_address,
  output logic        ppl_unlock
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  logic [1:0]    state    [2];
  logic [CW-1:0] wcnt     [2];
  logic [31:0]   laddr    [2];
  logic [31:0]   addr     [2];
  logic [32:0]   entry    [2];
  logic          req      [2];
  logic          rel      [2];
  logic          lock_q   [2];
  logic          unlock_q [2];
  logic          gnt_q    [2];
  logic          fail_q   [2];
  logic          ack_q    [2];
  logic          elig     [2];
  logic          base_cf  [2];
  logic          cf       [2];
  logic          tie;
  logic          rr;
  logic          unused_bits;

  function automatic logic word_eq(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction

  assign req[0]   = ooo_acq_req;
  assign req[1]   = ppl_acq_req;
  assign rel[0]   = ooo_rel_req;
  assign rel[1]   = ppl_rel_req;
  assign addr[0]  = ooo_acq_addr;
  assign addr[1]  = ppl_acq_addr;
  assign entry[0] = this_address_locked_by_ooo;
  assign entry[1] = this_address_locked_by_ppl;
  assign unused_bits = ^{entry[0][1:0], entry[1][1:0]};

  assign tie = elig[0] && elig[1] && !base_cf[0] && !base_cf[1]
               && word_eq(addr[0][31:2], addr[1][31:2]);

  for (genvar g = 0; g < 2; g++) begin : g_core
    localparam int O = 1 - g;

    assign elig[g] = req[g] && (state[g] != S_HELD);

    // A table entry whose unlock is already in flight no longer blocks, so a
    // waiter can be granted the cycle after the owner leaves HELD.
    assign base_cf[g] =
        (entry[O][32] && !unlock_q[O] && word_eq(entry[O][31:2], addr[g][31:2]))
      || (lock_q[O] && word_eq(laddr[O][31:2], addr[g][31:2]))
      || ((state[O] == S_HELD) && word_eq(laddr[O][31:2], addr[g][31:2]));

    assign cf[g] = base_cf[g] || (tie && (rr == 1'(O)));

    always_ff @(posedge clk) begin
      if (rst) begin
        state[g]    <= S_IDLE;
        wcnt[g]     <= '0;
        laddr[g]    <= '0;
        lock_q[g]   <= 1'b0;
        unlock_q[g] <= 1'b0;
        gnt_q[g]    <= 1'b0;
        fail_q[g]   <= 1'b0;
        ack_q[g]    <= 1'b0;
      end else begin
        lock_q[g]   <= 1'b0;
        unlock_q[g] <= 1'b0;
        gnt_q[g]    <= 1'b0;
        fail_q[g]   <= 1'b0;
        ack_q[g]    <= rel[g];
        case (state[g])
          S_IDLE: begin
            if (req[g]) begin
              if (!cf[g]) begin
                lock_q[g] <= 1'b1;
                gnt_q[g]  <= 1'b1;
                laddr[g]  <= addr[g];
                state[g]  <= S_HELD;
              end else begin
                wcnt[g]  <= CW'(1);
                state[g] <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (!req[g]) begin
              state[g] <= S_IDLE;
            end else if (!cf[g]) begin
              lock_q[g] <= 1'b1;
              gnt_q[g]  <= 1'b1;
              laddr[g]  <= addr[g];
              state[g]  <= S_HELD;
            end else if (wcnt[g] == CW'(MAX_WAIT)) begin
              fail_q[g] <= 1'b1;
              state[g]  <= S_IDLE;
            end else begin
              wcnt[g] <= wcnt[g] + 1'b1;
            end
          end
          S_HELD: begin
            if (rel[g]) begin
              unlock_q[g] <= 1'b1;
              state[g]    <= S_IDLE;
            end
          end
          default: state[g] <= S_IDLE;
        endcase
      end
    end
  end

  // rr names the loser of the most recent same-word tie, so it wins the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (tie) begin
      rr <= ~rr;
    end
  end

  assign ooo_acq_gnt        = gnt_q[0];
  assign ooo_acq_fail       = fail_q[0];
  assign ooo_rel_ack        = ack_q[0];
  assign ooo_lock           = lock_q[0];
  assign ooo_locked_address = laddr[0];
  assign ooo_unlock         = unlock_q[0];
  assign ppl_acq_gnt        = gnt_q[1];
  assign ppl_acq_fail       = fail_q[1];
  assign ppl_rel_ack        = ack_q[1];
  assign ppl_lock           = lock_q[1];
  assign ppl_locked_address = laddr[1];
  assign ppl_unlock         = unlock_q[1];

endmodule

// File: tb/tb_atomic_lock_arbiter.sv
// Bench for atomic_lock_arbiter: directed scenarios, then random traffic, all checked
// every cycle against an ownership-level model; lock_table is emulated locally.
module tb_atomic_lock_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ooo_acq_req, ppl_acq_req;
  logic [31:0] ooo_acq_addr, ppl_acq_addr;
  logic        ooo_rel_req, ppl_rel_req;
  logic        ooo_acq_gnt, ooo_acq_fail, ooo_rel_ack;
  logic        ppl_acq_gnt, ppl_acq_fail, ppl_rel_ack;
  logic [32:0] tab_o, tab_p;
  logic        ooo_lock, ooo_unlock, ppl_lock, ppl_unlock;
  logic [31:0] ooo_locked_address, ppl_locked_address;

  int n_cmp = 0;
  int n_bad = 0;

  atomic_lock_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .ooo_acq_req(ooo_acq_req), .ooo_acq_addr(ooo_acq_addr),
    .ooo_acq_gnt(ooo_acq_gnt), .ooo_acq_fail(ooo_acq_fail),
    .ooo_rel_req(ooo_rel_req), .ooo_rel_ack(ooo_rel_ack),
    .ppl_acq_req(ppl_acq_req), .ppl_acq_addr(ppl_acq_addr),
    .ppl_acq_gnt(ppl_acq_gnt), .ppl_acq_fail(ppl_acq_fail),
    .ppl_rel_req(ppl_rel_req), .ppl_rel_ack(ppl_rel_ack),
    .this_address_locked_by_ooo(tab_o), .this_address_locked_by_ppl(tab_p),
    .ooo_lock(ooo_lock), .ooo_locked_address(ooo_locked_address), .ooo_unlock(ooo_unlock),
    .ppl_lock(ppl_lock), .ppl_locked_address(ppl_locked_address), .ppl_unlock(ppl_unlock)
  );

  always #5 clk = ~clk;

  // Minimal lock_table stand-in: entry valid the cycle after the lock pulse.
  always @(posedge clk) begin
    if (rst) begin
      tab_o <= '0;
      tab_p <= '0;
    end else begin
      if (ooo_lock) tab_o <= {1'b1, ooo_locked_address};
      else if (ooo_unlock) tab_o[32] <= 1'b0;
      if (ppl_lock) tab_p <= {1'b1, ppl_locked_address};
      else if (ppl_unlock) tab_p[32] <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns which word, who is waiting and since which cycle.
  bit          held [2];
  logic [31:0] hadr [2];
  bit          waiting [2];
  int          since [2];
  bit          rr_m;
  bit          model_ok = 1'b0;
  int          stepn = 0;
  bit          e_gnt [2], e_fail [2], e_ack [2], e_lock [2], e_unlock [2], e_achk [2];
  logic [31:0] e_addr [2];

  always @(negedge clk) begin
    bit          q [2];
    bit          rl [2];
    bit          cand [2];
    bit          win [2];
    bit          tie_m;
    logic [31:0] a [2];
    if (model_ok) begin
      chk("ooo_acq_gnt", ooo_acq_gnt, e_gnt[0]);
      chk("ppl_acq_gnt", ppl_acq_gnt, e_gnt[1]);
      chk("ooo_acq_fail", ooo_acq_fail, e_fail[0]);
      chk("ppl_acq_fail", ppl_acq_fail, e_fail[1]);
      chk("ooo_rel_ack", ooo_rel_ack, e_ack[0]);
      chk("ppl_rel_ack", ppl_rel_ack, e_ack[1]);
      chk("ooo_lock", ooo_lock, e_lock[0]);
      chk("ppl_lock", ppl_lock, e_lock[1]);
      chk("ooo_unlock", ooo_unlock, e_unlock[0]);
      chk("ppl_unlock", ppl_unlock, e_unlock[1]);
      if (e_achk[0]) chk("ooo_locked_address", ooo_locked_address, e_addr[0]);
      if (e_achk[1]) chk("ppl_locked_address", ppl_locked_address, e_addr[1]);
    end
    q[0] = ooo_acq_req;  q[1] = ppl_acq_req;
    rl[0] = ooo_rel_req; rl[1] = ppl_rel_req;
    a[0] = ooo_acq_addr; a[1] = ppl_acq_addr;
    if (rst) begin
      rr_m = 1'b0;
      for (int i = 0; i < 2; i++) begin
        held[i] = 1'b0; waiting[i] = 1'b0;
        e_gnt[i] = 1'b0; e_fail[i] = 1'b0; e_ack[i] = 1'b0;
        e_lock[i] = 1'b0; e_unlock[i] = 1'b0;
        e_addr[i] = '0; e_achk[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int o;
        o = 1 - i;
        cand[i] = q[i] && !held[i] && !(held[o] && hadr[o][31:2] == a[i][31:2]);
      end
      tie_m = cand[0] && cand[1] && (a[0][31:2] == a[1][31:2]);
      win[0] = cand[0] && !(tie_m && rr_m);
      win[1] = cand[1] && !(tie_m && !rr_m);
      if (tie_m) rr_m = !rr_m;
      for (int i = 0; i < 2; i++) begin
        e_gnt[i] = 1'b0; e_fail[i] = 1'b0; e_lock[i] = 1'b0; e_unlock[i] = 1'b0;
        e_achk[i] = 1'b0; e_ack[i] = rl[i];
        if (held[i]) begin
          if (rl[i]) begin
            held[i] = 1'b0;
            e_unlock[i] = 1'b1;
          end
        end else if (!q[i]) begin
          waiting[i] = 1'b0;
        end else if (win[i]) begin
          held[i] = 1'b1; hadr[i] = a[i]; waiting[i] = 1'b0;
          e_lock[i] = 1'b1; e_gnt[i] = 1'b1; e_addr[i] = a[i]; e_achk[i] = 1'b1;
        end else if (!waiting[i]) begin
          waiting[i] = 1'b1;
          since[i] = stepn;
        end else if (stepn - since[i] == MW) begin
          e_fail[i] = 1'b1;
          waiting[i] = 1'b0;
        end
      end
    end
    model_ok = 1'b1;
    stepn++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic rnd_core(input logic req_in, input logic [31:0] a_in,
                          output logic req_o, output logic [31:0] a_o, output logic rel_o);
    logic [31:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h101; pool[2] = 32'h104; pool[3] = 32'h200;
    req_o = req_in;
    a_o   = a_in;
    if (req_in) begin
      if ($urandom_range(5) == 0) req_o = 1'b0;
    end else if ($urandom_range(2) == 0) begin
      req_o = 1'b1;
      a_o   = pool[$urandom_range(3)];
    end
    rel_o = ($urandom_range(7) == 0);
  endtask

  initial begin
    rst = 1'b1;
    ooo_acq_req = 1'b0; ppl_acq_req = 1'b0;
    ooo_acq_addr = '0;  ppl_acq_addr = '0;
    ooo_rel_req = 1'b0; ppl_rel_req = 1'b0;
    repeat (2) cyc();
    chk("reset_ooo_lock", ooo_lock, 1'b0);
    chk("reset_ooo_addr", ooo_locked_address, 32'h0);
    rst = 1'b0;
    cyc();

    // Uncontended acquire and release
    ooo_acq_addr = 32'h1000; ooo_acq_req = 1'b1;
    cyc();
    chk("t1_gnt", ooo_acq_gnt, 1'b1);
    chk("t1_lock", ooo_lock, 1'b1);
    chk("t1_addr", ooo_locked_address, 32'h1000);
    ooo_acq_req = 1'b0;
    cyc();
    chk("t1_table", tab_o, 33'h1_0000_1000);
    ooo_rel_req = 1'b1;
    cyc();
    chk("t1_rel_ack", ooo_rel_ack, 1'b1);
    chk("t1_unlock", ooo_unlock, 1'b1);
    ooo_rel_req = 1'b0;
    cyc();
    chk("t1_table_clr", tab_o[32], 1'b0);

    // Same-cycle tie, twice
    ooo_acq_addr = 32'h2004; ppl_acq_addr = 32'h2004;
    ooo_acq_req = 1'b1; ppl_acq_req = 1'b1;
    cyc();
    chk("t2_ooo_gnt", ooo_acq_gnt, 1'b1);
    chk("t2_ppl_gnt", ppl_acq_gnt, 1'b0);
    ooo_acq_req = 1'b0; ppl_acq_req = 1'b0;
    cyc();
    ooo_rel_req = 1'b1;
    cyc();
    ooo_rel_req = 1'b0;
    cyc();
    ooo_acq_req = 1'b1; ppl_acq_req = 1'b1;
    cyc();
    chk("t2b_ppl_gnt", ppl_acq_gnt, 1'b1);
    chk("t2b_ooo_gnt", ooo_acq_gnt, 1'b0);
    ooo_acq_req = 1'b0; ppl_acq_req = 1'b0;
    cyc();
    ppl_rel_req = 1'b1;
    cyc();
    ppl_rel_req = 1'b0;
    cyc();

    // Word aliasing
    ooo_acq_addr = 32'h3000; ooo_acq_req = 1'b1;
    cyc();
    chk("t3_ooo_gnt", ooo_acq_gnt, 1'b1);
    ooo_acq_req = 1'b0;
    ppl_acq_addr = 32'h3003; ppl_acq_req = 1'b1;
    cyc();
    chk("t3_alias_blk", ppl_acq_gnt, 1'b0);
    cyc();
    chk("t3_alias_blk2", ppl_lock, 1'b0);
    ppl_acq_req = 1'b0;
    cyc();
    ppl_acq_addr = 32'h3004; ppl_acq_req = 1'b1;
    cyc();
    chk("t3_next_word_gnt", ppl_acq_gnt, 1'b1);
    chk("t3_next_word_addr", ppl_locked_address, 32'h3004);
    ppl_acq_req = 1'b0;
    ooo_rel_req = 1'b1; ppl_rel_req = 1'b1;
    cyc();
    ooo_rel_req = 1'b0; ppl_rel_req = 1'b0;
    cyc();

    // Timeout
    ppl_acq_addr = 32'h40; ppl_acq_req = 1'b1;
    cyc();
    chk("t4_ppl_gnt", ppl_acq_gnt, 1'b1);
    ppl_acq_req = 1'b0;
    ooo_acq_addr = 32'h40; ooo_acq_req = 1'b1;
    cyc();
    for (int k = 1; k <= MW; k++) begin
      chk("t4_no_fail_early", ooo_acq_fail, 1'b0);
      chk("t4_no_lock", ooo_lock, 1'b0);
      cyc();
    end
    chk("t4_fail", ooo_acq_fail, 1'b1);
    chk("t4_fail_no_lock", ooo_lock, 1'b0);
    ooo_acq_req = 1'b0;
    cyc();
    ppl_rel_req = 1'b1;
    cyc();
    ppl_rel_req = 1'b0;
    cyc();

    // Handoff from PPL to a waiting OOO
    ppl_acq_addr = 32'h50; ppl_acq_req = 1'b1;
    cyc();
    chk("t5_ppl_gnt", ppl_acq_gnt, 1'b1);
    ppl_acq_req = 1'b0;
    ooo_acq_addr = 32'h50; ooo_acq_req = 1'b1;
    cyc();
    cyc();
    ppl_rel_req = 1'b1;
    cyc();
    chk("t5_ppl_unlock", ppl_unlock, 1'b1);
    chk("t5_ooo_not_yet", ooo_acq_gnt, 1'b0);
    ppl_rel_req = 1'b0;
    cyc();
    chk("t5_ooo_gnt", ooo_acq_gnt, 1'b1);
    chk("t5_ooo_addr", ooo_locked_address, 32'h50);
    ooo_acq_req = 1'b0;
    cyc();

    // Reset while OOO holds a lock, then a stray release
    rst = 1'b1;
    cyc();
    chk("t6_rst_lock", ooo_lock, 1'b0);
    chk("t6_rst_unlock", ooo_unlock, 1'b0);
    chk("t6_rst_ooo_addr", ooo_locked_address, 32'h0);
    chk("t6_rst_ppl_addr", ppl_locked_address, 32'h0);
    rst = 1'b0;
    cyc();
    ooo_rel_req = 1'b1;
    cyc();
    chk("t6_stray_ack", ooo_rel_ack, 1'b1);
    chk("t6_stray_unlock", ooo_unlock, 1'b0);
    ooo_rel_req = 1'b0;
    cyc();

    // Random traffic over a small address pool with aliasing words
    for (int n = 0; n < 3000; n++) begin
      logic        rq;
      logic [31:0] ad;
      logic        rl;
      rst = ($urandom_range(299) == 0);
      rnd_core(ooo_acq_req, ooo_acq_addr, rq, ad, rl);
      ooo_acq_req = rq; ooo_acq_addr = ad; ooo_rel_req = rl;
      rnd_core(ppl_acq_req, ppl_acq_addr, rq, ad, rl);
      ppl_acq_req = rq; ppl_acq_addr = ad; ppl_rel_req = rl;
      cyc();
    end
    rst = 1'b0;
    ooo_acq_req = 1'b0; ppl_acq_req = 1'b0;
    ooo_rel_req = 1'b0; ppl_rel_req = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
